emulate_hbm_mem: RTL

- Parametrised AXI4-MM slave that models one HBM pseudo-channel, with real backing storage, burst reads and writes, byte strobes, and programmable read latency.
- Sits in place of an HBM port in simulation and FPGA loopback builds, so CGRA kernels can be exercised without the HBM IP.
- Read and write channels run independently and concurrently. Both share one dual-port word array.

---
 rtl/hbm_emu_pkg.sv | 30 +++
 rtl/hbm_emu_ram.sv | 45 ++++
 rtl/emulate_hbm_mem.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/hbm_emu_pkg.sv
// Shared types and helpers for the HBM pseudo-channel emulator.
package hbm_emu_pkg;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_WAIT  = 2'd1,
    R_BURST = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Byte address to word index, wrapped to the storage depth (depth is a power of two).
  function automatic logic [63:0] addr2idx(input logic [63:0] addr,
                                           input int unsigned byte_shift,
                                           input int unsigned depth);
    return (addr >> byte_shift) & (64'(depth) - 64'd1);
  endfunction

  function automatic logic [7:0] clip_len(input logic [7:0] len, input int unsigned max_len);
    return (32'(len) > max_len) ? 8'(max_len) : len;
  endfunction

endpackage

// File: rtl/hbm_emu_ram.sv
// Dual-port word store: one registered read-first read port, one byte-enabled write port.
module hbm_emu_ram #(
  parameter int DATA_W = 512,
  parameter int DEPTH  = 1024,
  parameter int IDX_W  = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_en,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [DATA_W-1:0]     rd_data,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [DATA_W/8-1:0]   wr_strb,
  input  logic [DATA_W-1:0]     wr_data
);

  localparam int STRB_W = DATA_W / 8;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] rd_data_r;

  // Byte-masked write; storage is deliberately left unreset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wr_strb[i]) begin
          mem_r[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  // Registered read; holds its value while rd_en is low so stalled beats stay stable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_r <= '0;
    end else if (rd_en) begin
      rd_data_r <= mem_r[rd_idx];
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/emulate_hbm_mem.sv
// AXI4-MM slave emulating one HBM pseudo-channel with independent read and write engines.
module emulate_hbm_mem
  import hbm_emu_pkg::*;
#(
  parameter int DATA_W  = 512,
  parameter int ADDR_W  = 64,
  parameter int DEPTH   = 1024,
  parameter int RD_LAT  = 4,
  parameter int MAX_LEN = 255
) (
  input  logic                ap_clk,
  input  logic                ap_rst_n,
  input  logic [ADDR_W-1:0]   axi_araddr,
  input  logic [7:0]          axi_arlen,
  input  logic                axi_arvalid,
  output logic                axi_arready,
  output logic [DATA_W-1:0]   axi_rdata,
  output logic [1:0]          axi_rresp,
  output logic                axi_rlast,
  output logic                axi_rvalid,
  input  logic                axi_rready,
  input  logic [ADDR_W-1:0]   axi_awaddr,
  input  logic [7:0]          axi_awlen,
  input  logic                axi_awvalid,
  output logic                axi_awready,
  input  logic [DATA_W-1:0]   axi_wdata,
  input  logic [DATA_W/8-1:0] axi_wstrb,
  input  logic                axi_wlast,
  input  logic                axi_wvalid,
  output logic                axi_wready,
  output logic [1:0]          axi_bresp,
  output logic                axi_bvalid,
  input  logic                axi_bready
);

  localparam int STRB_W  = DATA_W / 8;
  localparam int BYTE_SH = $clog2(STRB_W);
  localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  rd_state_t         rd_state_r;
  logic [IDX_W-1:0]  rd_idx_r;
  logic [7:0]        rd_len_r;
  logic [7:0]        rd_beat_r;
  logic [CNT_W-1:0]  rd_cnt_r;
  logic              arready_r;
  logic              rvalid_r;
  logic              rlast_r;

  wr_state_t         wr_state_r;
  logic [IDX_W-1:0]  wr_idx_r;
  logic [7:0]        wr_len_r;
  logic [7:0]        wr_beat_r;
  logic              awready_r;
  logic              wready_r;
  logic              bvalid_r;
  logic [1:0]        bresp_r;

  logic              ar_hs_s;
  logic              aw_hs_s;
  logic              w_hs_s;
  logic [IDX_W-1:0]  ar_idx_s;
  logic [IDX_W-1:0]  aw_idx_s;
  logic [7:0]        ar_len_s;
  logic [7:0]        aw_len_s;
  logic              ram_rd_en_s;
  logic [IDX_W-1:0]  ram_rd_idx_s;

  assign ar_hs_s  = axi_arvalid && arready_r;
  assign aw_hs_s  = axi_awvalid && awready_r;
  assign w_hs_s   = axi_wvalid && wready_r;
  assign ar_idx_s = IDX_W'(addr2idx(64'(axi_araddr), BYTE_SH, DEPTH));
  assign aw_idx_s = IDX_W'(addr2idx(64'(axi_awaddr), BYTE_SH, DEPTH));
  assign ar_len_s = clip_len(axi_arlen, MAX_LEN);
  assign aw_len_s = clip_len(axi_awlen, MAX_LEN);

  // RAM fetch is issued on the same edge that raises or advances rvalid, so data lands with it
  always_comb begin
    ram_rd_en_s  = 1'b0;
    ram_rd_idx_s = rd_idx_r;
    case (rd_state_r)
      R_IDLE: begin
        if (ar_hs_s && (RD_LAT == 1)) begin
          ram_rd_en_s  = 1'b1;
          ram_rd_idx_s = ar_idx_s;
        end else begin
          ram_rd_en_s  = 1'b0;
        end
      end
      R_WAIT:  ram_rd_en_s = (rd_cnt_r == CNT_W'(1));
      R_BURST: ram_rd_en_s = axi_rready && !rlast_r;
      default: ram_rd_en_s = 1'b0;
    endcase
  end

  // Read engine: latency countdown, then len+1 beats with rready backpressure
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rd_state_r <= R_IDLE;
      rd_idx_r   <= '0;
      rd_len_r   <= 8'd0;
      rd_beat_r  <= 8'd0;
      rd_cnt_r   <= '0;
      arready_r  <= 1'b0;
      rvalid_r   <= 1'b0;
      rlast_r    <= 1'b0;
    end else begin
      case (rd_state_r)
        R_IDLE: begin
          arready_r <= 1'b1;
          if (ar_hs_s) begin
            arready_r <= 1'b0;
            rd_len_r  <= ar_len_s;
            rd_beat_r <= 8'd0;
            if (RD_LAT == 1) begin
              rd_state_r <= R_BURST;
              rd_idx_r   <= ar_idx_s + IDX_W'(1);
              rvalid_r   <= 1'b1;
              rlast_r    <= (ar_len_s == 8'd0);
            end else begin
              rd_state_r <= R_WAIT;
              rd_idx_r   <= ar_idx_s;
              rd_cnt_r   <= CNT_W'(RD_LAT - 1);
            end
          end
        end
        R_WAIT: begin
          if (rd_cnt_r == CNT_W'(1)) begin
            rd_state_r <= R_BURST;
            rd_idx_r   <= rd_idx_r + IDX_W'(1);
            rvalid_r   <= 1'b1;
            rlast_r    <= (rd_len_r == 8'd0);
          end else begin
            rd_cnt_r   <= rd_cnt_r - CNT_W'(1);
          end
        end
        R_BURST: begin
          if (axi_rready) begin
            if (rlast_r) begin
              rd_state_r <= R_IDLE;
              rvalid_r   <= 1'b0;
              rlast_r    <= 1'b0;
              arready_r  <= 1'b1;
            end else begin
              rd_idx_r   <= rd_idx_r + IDX_W'(1);
              rd_beat_r  <= rd_beat_r + 8'd1;
              rlast_r    <= ((rd_beat_r + 8'd1) == rd_len_r);
            end
          end
        end
        default: rd_state_r <= R_IDLE;
      endcase
    end
  end

  // Write engine: commits every accepted beat, ends on wlast or the len-th beat
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_state_r <= W_IDLE;
      wr_idx_r   <= '0;
      wr_len_r   <= 8'd0;
      wr_beat_r  <= 8'd0;
      awready_r  <= 1'b0;
      wready_r   <= 1'b0;
      bvalid_r   <= 1'b0;
      bresp_r    <= RESP_OKAY;
    end else begin
      case (wr_state_r)
        W_IDLE: begin
          awready_r <= 1'b1;
          if (aw_hs_s) begin
            awready_r  <= 1'b0;
            wready_r   <= 1'b1;
            wr_idx_r   <= aw_idx_s;
            wr_len_r   <= aw_len_s;
            wr_beat_r  <= 8'd0;
            wr_state_r <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs_s) begin
            wr_idx_r  <= wr_idx_r + IDX_W'(1);
            wr_beat_r <= wr_beat_r + 8'd1;
            if (axi_wlast || (wr_beat_r == wr_len_r)) begin
              wr_state_r <= W_RESP;
              wready_r   <= 1'b0;
              bvalid_r   <= 1'b1;
              bresp_r    <= (axi_wlast == (wr_beat_r == wr_len_r)) ? RESP_OKAY : RESP_SLVERR;
            end
          end
        end
        W_RESP: begin
          if (axi_bready) begin
            bvalid_r   <= 1'b0;
            bresp_r    <= RESP_OKAY;
            awready_r  <= 1'b1;
            wr_state_r <= W_IDLE;
          end
        end
        default: wr_state_r <= W_IDLE;
      endcase
    end
  end

  hbm_emu_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_ram (
    .clk     (ap_clk),
    .rst_n   (ap_rst_n),
    .rd_en   (ram_rd_en_s),
    .rd_idx  (ram_rd_idx_s),
    .rd_data (axi_rdata),
    .wr_en   (w_hs_s),
    .wr_idx  (wr_idx_r),
    .wr_strb (axi_wstrb),
    .wr_data (axi_wdata)
  );

  assign axi_arready = arready_r;
  assign axi_rvalid  = rvalid_r;
  assign axi_rlast   = rlast_r;
  assign axi_rresp   = RESP_OKAY;
  assign axi_awready = awready_r;
  assign axi_wready  = wready_r;
  assign axi_bvalid  = bvalid_r;
  assign axi_bresp   = bresp_r;

endmodule
